// File: rtl/cmsdk_mcu_mtx4x2_ip_hold_pkg.sv
// Shared definitions for the bus-matrix input stage: AHB-Lite transfer, burst
// and response codes, field widths, and the stage's two state bits.
package cmsdk_mcu_mtx4x2_ip_hold_pkg;

  localparam int TRANS_W  = 2;
  localparam int SIZE_W   = 3;
  localparam int BURST_W  = 3;
  localparam int PROT_W   = 4;
  localparam int MASTER_W = 4;
  localparam int RESP_W   = 2;

  typedef enum logic [TRANS_W-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [RESP_W-1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  localparam logic [BURST_W-1:0] HBURST_INCR = 3'b001;

  // Observable state of the input stage (it is a pair of flags, not an encoded FSM).
  typedef struct packed {
    logic pend_tran;
    logic data_phase;
  } hold_state_t;

endpackage

// File: rtl/cmsdk_mcu_mtx4x2_ip_hold_if.sv
// Master-facing AHB-Lite slave port of one bus-matrix input stage.
// Handshake: an address phase is offered when HSELS & HTRANSS[1] while HREADYS=1;
// it is taken when HREADYOUTS=1, which also completes the previous data phase.
interface cmsdk_mcu_mtx4x2_ip_hold_if
  import cmsdk_mcu_mtx4x2_ip_hold_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int USER_W = 3
);
  logic                HSELS;
  logic [ADDR_W-1:0]   HADDRS;
  logic [USER_W-1:0]   HAUSERS;
  logic [TRANS_W-1:0]  HTRANSS;
  logic                HWRITES;
  logic [SIZE_W-1:0]   HSIZES;
  logic [BURST_W-1:0]  HBURSTS;
  logic [PROT_W-1:0]   HPROTS;
  logic [MASTER_W-1:0] HMASTERS;
  logic                HMASTLOCKS;
  logic                HREADYS;
  logic                HREADYOUTS;
  logic [RESP_W-1:0]   HRESPS;

  modport master (
    output HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
           HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
    input  HREADYOUTS, HRESPS
  );

  modport slave (
    input  HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
           HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
    output HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/cmsdk_mcu_mtx4x2_ip_hold.sv
// Bus-matrix input stage: holds an address phase that no output stage granted and
// presents it (live or held) to the output stages; routes ready/response back.
module cmsdk_mcu_mtx4x2_ip_hold
  import cmsdk_mcu_mtx4x2_ip_hold_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int USER_W      = 3,
  parameter int BURST_BREAK = 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  cmsdk_mcu_mtx4x2_ip_hold_if.slave ahb,
  input  logic                active_ip,
  input  logic                readyout_ip,
  input  logic [RESP_W-1:0]   resp_ip,
  output logic                sel_ip,
  output logic [ADDR_W-1:0]   addr_ip,
  output logic [USER_W-1:0]   auser_ip,
  output logic [TRANS_W-1:0]  trans_ip,
  output logic                write_ip,
  output logic [SIZE_W-1:0]   size_ip,
  output logic [BURST_W-1:0]  burst_ip,
  output logic [PROT_W-1:0]   prot_ip,
  output logic [MASTER_W-1:0] master_ip,
  output logic                mastlock_ip,
  output logic                held_tran_ip
);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [USER_W-1:0]   auser;
    logic [TRANS_W-1:0]  trans;
    logic                write;
    logic [SIZE_W-1:0]   size;
    logic [BURST_W-1:0]  burst;
    logic [PROT_W-1:0]   prot;
    logic [MASTER_W-1:0] master;
    logic                mastlock;
  } xfer_t;

  xfer_t       live_x;
  xfer_t       hold_q, hold_d;
  xfer_t       out_x;
  hold_state_t state_q, state_d;
  logic        new_tran;
  logic        unused_resp_hi;

  assign new_tran       = ahb.HSELS & ahb.HREADYS & ahb.HTRANSS[1];
  assign unused_resp_hi = resp_ip[1];

  always_comb begin
    live_x          = '0;
    live_x.addr     = ahb.HADDRS;
    live_x.auser    = ahb.HAUSERS;
    live_x.trans    = ahb.HTRANSS;
    live_x.write    = ahb.HWRITES;
    live_x.size     = ahb.HSIZES;
    live_x.burst    = ahb.HBURSTS;
    live_x.prot     = ahb.HPROTS;
    live_x.master   = ahb.HMASTERS;
    live_x.mastlock = ahb.HMASTLOCKS;
  end

  always_comb begin
    hold_d  = hold_q;
    state_d = state_q;
    // Freeze the captured fields while a transfer is pending so the held request stays intact.
    if (ahb.HREADYS && !state_q.pend_tran) begin
      hold_d = live_x;
    end
    if (state_q.pend_tran) begin
      state_d.pend_tran = ~(active_ip & readyout_ip);
    end else begin
      state_d.pend_tran = new_tran & ~active_ip;
    end
    if (active_ip && held_tran_ip && readyout_ip) begin
      state_d.data_phase = 1'b1;
    end else if (readyout_ip) begin
      state_d.data_phase = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_q  <= '0;
      state_q <= '0;
    end else begin
      hold_q  <= hold_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    out_x        = live_x;
    sel_ip       = ahb.HSELS;
    held_tran_ip = new_tran;
    if (state_q.pend_tran) begin
      out_x        = hold_q;
      sel_ip       = 1'b1;
      held_tran_ip = 1'b1;
      // A re-issued SEQ has lost its burst context, so restart it as an INCR NONSEQ.
      if ((BURST_BREAK != 0) && (hold_q.trans == HTRANS_SEQ)) begin
        out_x.trans = HTRANS_NONSEQ;
        out_x.burst = HBURST_INCR;
      end
    end
  end

  assign addr_ip     = out_x.addr;
  assign auser_ip    = out_x.auser;
  assign trans_ip    = out_x.trans;
  assign write_ip    = out_x.write;
  assign size_ip     = out_x.size;
  assign burst_ip    = out_x.burst;
  assign prot_ip     = out_x.prot;
  assign master_ip   = out_x.master;
  assign mastlock_ip = out_x.mastlock;

  always_comb begin
    ahb.HREADYOUTS = 1'b1;
    ahb.HRESPS     = HRESP_OKAY;
    if (state_q.pend_tran) begin
      ahb.HREADYOUTS = 1'b0;
    end else if (state_q.data_phase) begin
      ahb.HREADYOUTS = readyout_ip;
    end
    if (state_q.data_phase) begin
      ahb.HRESPS = {1'b0, resp_ip[0]};
    end
  end

endmodule

// File: tb/tb_cmsdk_mcu_mtx4x2_ip_hold.sv
// Directed bench for the bus-matrix input stage: a cycle table run against a
// BURST_BREAK=1 and a BURST_BREAK=0 instance, plus hand-written hold/reset sequences.
module tb_cmsdk_mcu_mtx4x2_ip_hold;

  logic       clk;
  logic       rst_n;
  logic       active_ip;
  logic       readyout_ip;
  logic [1:0] resp_ip;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  cmsdk_mcu_mtx4x2_ip_hold_if #(.ADDR_W(32), .USER_W(3)) bus ();
  cmsdk_mcu_mtx4x2_ip_hold_if #(.ADDR_W(32), .USER_W(3)) bus0 ();

  assign bus0.HSELS      = bus.HSELS;
  assign bus0.HADDRS     = bus.HADDRS;
  assign bus0.HAUSERS    = bus.HAUSERS;
  assign bus0.HTRANSS    = bus.HTRANSS;
  assign bus0.HWRITES    = bus.HWRITES;
  assign bus0.HSIZES     = bus.HSIZES;
  assign bus0.HBURSTS    = bus.HBURSTS;
  assign bus0.HPROTS     = bus.HPROTS;
  assign bus0.HMASTERS   = bus.HMASTERS;
  assign bus0.HMASTLOCKS = bus.HMASTLOCKS;
  assign bus0.HREADYS    = bus.HREADYS;

  logic        sel_ip, write_ip, mastlock_ip, held_tran_ip;
  logic [31:0] addr_ip;
  logic [2:0]  auser_ip, size_ip, burst_ip;
  logic [1:0]  trans_ip;
  logic [3:0]  prot_ip, master_ip;

  logic        sel_ip0, write_ip0, mastlock_ip0, held_tran_ip0;
  logic [31:0] addr_ip0;
  logic [2:0]  auser_ip0, size_ip0, burst_ip0;
  logic [1:0]  trans_ip0;
  logic [3:0]  prot_ip0, master_ip0;

  cmsdk_mcu_mtx4x2_ip_hold #(.ADDR_W(32), .USER_W(3), .BURST_BREAK(1)) dut (
    .HCLK(clk), .HRESETn(rst_n), .ahb(bus),
    .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
    .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip),
    .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
    .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip)
  );

  cmsdk_mcu_mtx4x2_ip_hold #(.ADDR_W(32), .USER_W(3), .BURST_BREAK(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .ahb(bus0),
    .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
    .sel_ip(sel_ip0), .addr_ip(addr_ip0), .auser_ip(auser_ip0), .trans_ip(trans_ip0),
    .write_ip(write_ip0), .size_ip(size_ip0), .burst_ip(burst_ip0), .prot_ip(prot_ip0),
    .master_ip(master_ip0), .mastlock_ip(mastlock_ip0), .held_tran_ip(held_tran_ip0)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel;
    logic        rdys;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic        act;
    logic        rdy;
    logic [1:0]  resp;
    logic        e_sel;
    logic        e_held;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic [2:0]  e_burst;
    logic [1:0]  e_trans0;
    logic [2:0]  e_burst0;
    logic        e_hrdy;
    logic [1:0]  e_hresp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sel, input logic rdys, input logic [1:0] trans,
                     input logic [31:0] addr, input logic [2:0] burst, input logic act,
                     input logic rdy, input logic [1:0] resp, input logic e_sel,
                     input logic e_held, input logic [1:0] e_trans, input logic [31:0] e_addr,
                     input logic [2:0] e_burst, input logic [1:0] e_trans0,
                     input logic [2:0] e_burst0, input logic e_hrdy, input logic [1:0] e_hresp);
    vec_t v;
    v.sel = sel; v.rdys = rdys; v.trans = trans; v.addr = addr; v.burst = burst;
    v.act = act; v.rdy = rdy; v.resp = resp;
    v.e_sel = e_sel; v.e_held = e_held; v.e_trans = e_trans; v.e_addr = e_addr;
    v.e_burst = e_burst; v.e_trans0 = e_trans0; v.e_burst0 = e_burst0;
    v.e_hrdy = e_hrdy; v.e_hresp = e_hresp;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_default();
    bus.HSELS = 1'b0; bus.HADDRS = '0; bus.HAUSERS = '0; bus.HTRANSS = 2'b00;
    bus.HWRITES = 1'b0; bus.HSIZES = 3'd2; bus.HBURSTS = 3'd0; bus.HPROTS = 4'h3;
    bus.HMASTERS = 4'h1; bus.HMASTLOCKS = 1'b0; bus.HREADYS = 1'b1;
    active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = 2'b00;
  endtask

  task automatic apply(input vec_t v);
    bus.HSELS = v.sel; bus.HREADYS = v.rdys; bus.HTRANSS = v.trans;
    bus.HADDRS = v.addr; bus.HBURSTS = v.burst;
    active_ip = v.act; readyout_ip = v.rdy; resp_ip = v.resp;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  initial begin
    drive_default();
    rst_n = 1'b0;
    #3;
    chk("reset HREADYOUTS", 32'(bus.HREADYOUTS), 32'h1);
    chk("reset HRESPS", 32'(bus.HRESPS), 32'h0);
    chk("reset held_tran_ip", 32'(held_tran_ip), 32'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    //  sel rdys trans addr          burst act rdy resp | sel held trans addr      burst trans0 burst0 hrdy hresp
    add(0, 1, 2'b00, 32'h0,          3'd0, 0, 1, 2'b00,  0, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 1, 2'b00);
    add(1, 1, 2'b10, 32'h2000_0000,  3'd1, 1, 1, 2'b00,  1, 1, 2'b10, 32'h2000_0000,  3'd1, 2'b10, 3'd1, 1, 2'b00);
    add(1, 1, 2'b00, 32'h2000_0004,  3'd0, 1, 1, 2'b00,  1, 0, 2'b00, 32'h2000_0004,  3'd0, 2'b00, 3'd0, 1, 2'b00);
    add(1, 1, 2'b10, 32'h4000_0010,  3'd0, 0, 1, 2'b00,  1, 1, 2'b10, 32'h4000_0010,  3'd0, 2'b10, 3'd0, 1, 2'b00);
    add(1, 0, 2'b10, 32'h5000_0000,  3'd0, 0, 1, 2'b00,  1, 1, 2'b10, 32'h4000_0010,  3'd0, 2'b10, 3'd0, 0, 2'b00);
    add(1, 0, 2'b10, 32'h6000_0000,  3'd0, 0, 1, 2'b00,  1, 1, 2'b10, 32'h4000_0010,  3'd0, 2'b10, 3'd0, 0, 2'b00);
    add(1, 0, 2'b10, 32'h6000_0000,  3'd0, 1, 1, 2'b00,  1, 1, 2'b10, 32'h4000_0010,  3'd0, 2'b10, 3'd0, 0, 2'b00);
    add(1, 0, 2'b00, 32'h0,          3'd0, 1, 0, 2'b00,  1, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 0, 2'b00);
    add(1, 1, 2'b00, 32'h0,          3'd0, 1, 1, 2'b00,  1, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 1, 2'b00);
    add(1, 1, 2'b10, 32'h2000_0100,  3'd0, 1, 1, 2'b00,  1, 1, 2'b10, 32'h2000_0100,  3'd0, 2'b10, 3'd0, 1, 2'b00);
    add(1, 0, 2'b00, 32'h0,          3'd0, 1, 0, 2'b01,  1, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 0, 2'b01);
    add(1, 1, 2'b00, 32'h0,          3'd0, 1, 1, 2'b01,  1, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 1, 2'b01);
    add(0, 1, 2'b00, 32'h0,          3'd0, 0, 1, 2'b01,  0, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 1, 2'b00);
    add(1, 1, 2'b11, 32'h3000_0004,  3'd3, 0, 1, 2'b00,  1, 1, 2'b11, 32'h3000_0004,  3'd3, 2'b11, 3'd3, 1, 2'b00);
    add(1, 0, 2'b11, 32'h3000_0008,  3'd3, 0, 1, 2'b00,  1, 1, 2'b10, 32'h3000_0004,  3'd1, 2'b11, 3'd3, 0, 2'b00);
    add(1, 0, 2'b11, 32'h3000_0008,  3'd3, 1, 1, 2'b00,  1, 1, 2'b10, 32'h3000_0004,  3'd1, 2'b11, 3'd3, 0, 2'b00);
    add(1, 1, 2'b00, 32'h0,          3'd0, 1, 1, 2'b00,  1, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 1, 2'b00);
    add(1, 1, 2'b10, 32'h2000_0200,  3'd0, 1, 1, 2'b00,  1, 1, 2'b10, 32'h2000_0200,  3'd0, 2'b10, 3'd0, 1, 2'b00);
    add(1, 1, 2'b10, 32'h2000_0300,  3'd0, 0, 0, 2'b01,  1, 1, 2'b10, 32'h2000_0300,  3'd0, 2'b10, 3'd0, 0, 2'b01);
    add(1, 0, 2'b00, 32'h0,          3'd0, 1, 1, 2'b01,  1, 1, 2'b10, 32'h2000_0300,  3'd0, 2'b10, 3'd0, 0, 2'b01);
    add(1, 0, 2'b00, 32'h0,          3'd0, 1, 0, 2'b00,  1, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 0, 2'b00);
    add(1, 1, 2'b00, 32'h0,          3'd0, 1, 1, 2'b00,  1, 0, 2'b00, 32'h0,          3'd0, 2'b00, 3'd0, 1, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("row%0d sel_ip", i),       32'(sel_ip),         32'(vecs[i].e_sel));
      chk($sformatf("row%0d held_tran_ip", i), 32'(held_tran_ip),   32'(vecs[i].e_held));
      chk($sformatf("row%0d trans_ip", i),     32'(trans_ip),       32'(vecs[i].e_trans));
      chk($sformatf("row%0d addr_ip", i),      addr_ip,             vecs[i].e_addr);
      chk($sformatf("row%0d burst_ip", i),     32'(burst_ip),       32'(vecs[i].e_burst));
      chk($sformatf("row%0d HREADYOUTS", i),   32'(bus.HREADYOUTS), 32'(vecs[i].e_hrdy));
      chk($sformatf("row%0d HRESPS", i),       32'(bus.HRESPS),     32'(vecs[i].e_hresp));
      chk($sformatf("row%0d nobreak trans_ip", i), 32'(trans_ip0),  32'(vecs[i].e_trans0));
      chk($sformatf("row%0d nobreak burst_ip", i), 32'(burst_ip0),  32'(vecs[i].e_burst0));
      chk($sformatf("row%0d nobreak HREADYOUTS", i), 32'(bus0.HREADYOUTS), 32'(vecs[i].e_hrdy));
      next_cycle();
    end

    // Held transfer keeps every attribute, including HMASTLOCKS, while the master changes them.
    bus.HSELS = 1'b1; bus.HREADYS = 1'b1; bus.HTRANSS = 2'b10; bus.HADDRS = 32'h1234_5678;
    bus.HBURSTS = 3'd0; bus.HWRITES = 1'b1; bus.HSIZES = 3'd2; bus.HPROTS = 4'hA;
    bus.HMASTERS = 4'h5; bus.HMASTLOCKS = 1'b1; bus.HAUSERS = 3'h6;
    active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = 2'b00;
    next_cycle();
    bus.HREADYS = 1'b0; bus.HTRANSS = 2'b00; bus.HADDRS = 32'h0; bus.HWRITES = 1'b0;
    bus.HSIZES = 3'd0; bus.HPROTS = 4'h0; bus.HMASTERS = 4'h0; bus.HMASTLOCKS = 1'b0;
    bus.HAUSERS = 3'h0;
    #2;
    chk("hold addr_ip", addr_ip, 32'h1234_5678);
    chk("hold write_ip", 32'(write_ip), 32'h1);
    chk("hold size_ip", 32'(size_ip), 32'h2);
    chk("hold prot_ip", 32'(prot_ip), 32'hA);
    chk("hold master_ip", 32'(master_ip), 32'h5);
    chk("hold mastlock_ip", 32'(mastlock_ip), 32'h1);
    chk("hold auser_ip", 32'(auser_ip), 32'h6);
    chk("hold HREADYOUTS", 32'(bus.HREADYOUTS), 32'h0);

    // Asynchronous reset in the middle of a hold: live inputs appear without a clock edge.
    rst_n = 1'b0;
    #1;
    chk("async rst HREADYOUTS", 32'(bus.HREADYOUTS), 32'h1);
    chk("async rst held_tran_ip", 32'(held_tran_ip), 32'h0);
    chk("async rst addr_ip live", addr_ip, 32'h0);
    chk("async rst mastlock_ip live", 32'(mastlock_ip), 32'h0);
    chk("async rst HRESPS", 32'(bus.HRESPS), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    drive_default();
    #2;
    chk("post rst HREADYOUTS", 32'(bus.HREADYOUTS), 32'h1);
    chk("post rst held_tran_ip", 32'(held_tran_ip), 32'h0);
    next_cycle();
    #2;
    chk("post rst idle HREADYOUTS", 32'(bus.HREADYOUTS), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
